branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  - EX-stage branch resolution controller. Instantiates branch_comp and computes the actual target.
//  - Detects mispredictions and sequences the fetch redirect through a valid/ready handshake.
//  - Flushes younger IF/ID instructions and stalls the pipeline until fetch accepts the redirect.
//  - Owns the branch history table (BHT) that fetch reads for direction prediction.
// PARAMETERS
//  BHT_IDX_W   6    log2 of BHT entries; index = pc[BHT_IDX_W+1:2]
//  CNT_INIT    2'b01  reset value of every 2-bit BHT counter (weakly not-taken)
// PORTS
//  clk_i          in   1          clock; all state updates on the rising edge
//  rst_i          in   1          asynchronous, active-high reset
//  ex_valid_i     in   1          EX holds a valid instruction
//  ex_pc_i        in   32         PC of the EX instruction
//  ex_imm_i       in   32         sign-extended immediate
//  rs1_i, rs2_i   in   32 each    operands; compared by branch_comp; rs1 is the JUMP_R base
//  br_cond_i      in   br_cond_e  branch condition from decode
//  opcode_i       in   rv32_opcodes_e  EX opcode
//  pred_taken_i   in   1          fetch-time direction prediction carried down the pipe
//  pred_target_i  in   32         fetch-time predicted target (meaningful only if pred_taken_i)
//  flush_o        out  1          combinational pulse: kill IF/ID instructions at this edge
//  stall_o        out  1          hold IF/ID/EX; high while a redirect is pending
//  redir_valid_o  out  1          redirect request to fetch
//  redir_pc_o     out  32         redirect PC; stable while redir_valid_o && !redir_ready_i
//  redir_ready_i  in   1          fetch accepts the redirect
//  if_pc_i        in   32         fetch PC for BHT lookup
//  bht_pred_o     out  1          combinational: BHT counter MSB at index(if_pc_i)
//  mispred_cnt_o  out  32         misprediction count; wraps at 2^32
// BEHAVIOUR
//  - Control-flow instruction (cf):
//    - br_cond_i in {BEQ, BNE, BLT, BGE, BLTU, BGEU} (conditional), or
//    - opcode_i in {JUMP, JUMP_R}.
//  - taken = branch_comp.branch_taken_o.
//  - Actual target:
//    - JUMP and conditional: ex_pc_i + ex_imm_i.
//    - JUMP_R: (rs1_i + ex_imm_i) & ~32'h1.
//    - All additions are 32-bit and wrap.
//  - next_pc = taken ? target : ex_pc_i + 4.
//  - mispredict = ex_valid_i & cf & state==IDLE & (taken != pred_taken_i | (taken & target != pred_target_i)).
//  - Non-cf instructions never mispredict, regardless of pred_taken_i.
//  - FSM states:
//    - IDLE:     mispredict -> REDIRECT; load redir_pc_o <= next_pc; flush_o=1 this cycle.
//    - REDIRECT: redir_valid_o=1, stall_o=1; redir_ready_i -> IDLE at the next edge.
//  - Latency: mispredict in cycle N -> redir_valid_o high in N+1. Minimum pending time is one cycle (ready already high in N+1).
//  - While in REDIRECT: ex_valid_i ignored; no BHT update, no count, no flush.
//  - flush_o is 0 in REDIRECT.
//  - BHT update, once per resolution:
//    - Condition: ex_valid_i & conditional & state==IDLE.
//    - Counter at index(ex_pc_i) saturating-increments if taken, decrements if not. Saturates at 2'b11 and 2'b00.
//    - JUMP and JUMP_R never touch the BHT.
//  - Same-cycle BHT update and lookup at the same index: bht_pred_o returns the old value (no bypass).
//  - mispred_cnt_o increments by 1 on each IDLE->REDIRECT transition.
//  - Reset (any cycle, including mid-REDIRECT), outputs:
//    - state=IDLE; redir_valid_o=0; redir_pc_o=0; stall_o=0; flush_o=0; mispred_cnt_o=0.
//    - All BHT counters = CNT_INIT.
//  - Reset wins over a same-cycle handshake; a pending redirect is dropped.
// STRUCTURE
//  - core_pkg: add redir_state_e {IDLE, REDIRECT}.
//  - core_pkg: add localparam BHT_CNT_W = 2 and a bht_cnt_t typedef.
//  - Sub-module: branch_comp (existing), instantiated once.
//  - BHT is a flop array in this module; no separate RAM module.
// TESTING
//  1. BEQ at pc=0x100, rs1=rs2=5, imm=0x20, pred_taken=0:
//     - flush_o=1 in N; redir_valid_o=1 with redir_pc_o=0x120 in N+1; mispred_cnt_o=1.
//  2. BNE, rs1=rs2, pred_taken=0 -> no flush, no redirect; BHT[idx] 01->00, bht_pred_o=0 for that pc.
//  3. JUMP_R, rs1=0x203, imm=0x4, pred_taken=1, pred_target=0x206:
//     - redir_pc_o=0x206 -> no redirect.
//     - Same case with pred_target=0x200 -> redirect to 0x206.
//  4. Redirect pending, redir_ready_i held low 3 cycles:
//     - redir_pc_o stable, stall_o=1; mispredicting ex_valid_i pulses ignored (count unchanged).
//     - ready=1 -> IDLE next cycle.
//  5. Three taken BLTs (rs1=-1, rs2=1) at the same pc -> counter 01->10->11->11; bht_pred_o=1 after the first.
//  6. Assert rst_i mid-REDIRECT -> redir_valid_o=0, mispred_cnt_o=0, bht_pred_o=0 for all PCs immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: decode enums, redirect FSM states and BHT counter helpers.
package core_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BEQ     = 3'd1,
      BNE     = 3'd2,
      BLT     = 3'd3,
      BGE     = 3'd4,
      BLTU    = 3'd5,
      BGEU    = 3'd6
   } br_cond_e;

   typedef enum logic [6:0] {
      OP_LOAD  = 7'b0000011,
      OP_IMM   = 7'b0010011,
      OP_AUIPC = 7'b0010111,
      OP_STORE = 7'b0100011,
      OP_REG   = 7'b0110011,
      OP_LUI   = 7'b0110111,
      BRANCH   = 7'b1100011,
      JUMP_R   = 7'b1100111,
      JUMP     = 7'b1101111
   } rv32_opcodes_e;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } redir_state_e;

   localparam int BHT_CNT_W = 2;
   typedef logic [BHT_CNT_W-1:0] bht_cnt_t;

   function automatic logic is_cond_br(br_cond_e c);
      return c inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
   endfunction

   // 2-bit saturating counter step
   function automatic bht_cnt_t bht_cnt_next(bht_cnt_t c, logic taken);
      if (taken) return (c == '1) ? c : c + bht_cnt_t'(1);
      else       return (c == '0) ? c : c - bht_cnt_t'(1);
   endfunction

endpackage

// File: rtl/branch_comp.sv
// Operand comparator: resolves conditional branch direction; jumps are always taken.
module branch_comp
   import core_pkg::*;
(
   input  logic [31:0]   rs1_i,
   input  logic [31:0]   rs2_i,
   input  br_cond_e      br_cond_i,
   input  rv32_opcodes_e opcode_i,
   output logic          branch_taken_o
);

   always_comb begin
      branch_taken_o = 1'b0;
      case (br_cond_i)
         BEQ:     branch_taken_o = (rs1_i == rs2_i);
         BNE:     branch_taken_o = (rs1_i != rs2_i);
         BLT:     branch_taken_o = ($signed(rs1_i) <  $signed(rs2_i));
         BGE:     branch_taken_o = ($signed(rs1_i) >= $signed(rs2_i));
         BLTU:    branch_taken_o = (rs1_i <  rs2_i);
         BGEU:    branch_taken_o = (rs1_i >= rs2_i);
         default: branch_taken_o = (opcode_i == JUMP) || (opcode_i == JUMP_R);
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: misprediction detect, fetch redirect handshake and BHT ownership.
// Redirect handshake: redir_valid_o stays high and redir_pc_o holds until a cycle with redir_ready_i high.
module branch_resolve_ctrl
   import core_pkg::*;
#(
   parameter int       BHT_IDX_W = 6,
   parameter bht_cnt_t CNT_INIT  = 2'b01
)(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ex_valid_i,
   input  logic [31:0]   ex_pc_i,
   input  logic [31:0]   ex_imm_i,
   input  logic [31:0]   rs1_i,
   input  logic [31:0]   rs2_i,
   input  br_cond_e      br_cond_i,
   input  rv32_opcodes_e opcode_i,
   input  logic          pred_taken_i,
   input  logic [31:0]   pred_target_i,
   output logic          flush_o,
   output logic          stall_o,
   output logic          redir_valid_o,
   output logic [31:0]   redir_pc_o,
   input  logic          redir_ready_i,
   input  logic [31:0]   if_pc_i,
   output logic          bht_pred_o,
   output logic [31:0]   mispred_cnt_o,
   output logic          dbg_state_o
);

   localparam int BHT_N = 1 << BHT_IDX_W;

   redir_state_e         state_q, state_d;
   logic                 taken, is_cond, is_cf, mispredict, bht_upd;
   logic [31:0]          target, next_pc;
   logic [31:0]          redir_pc_q, mispred_cnt_q;
   logic [BHT_IDX_W-1:0] ex_idx, if_idx;
   bht_cnt_t             bht_q [BHT_N];
   logic                 unused_if_pc;

   branch_comp u_branch_comp (
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .br_cond_i      (br_cond_i),
      .opcode_i       (opcode_i),
      .branch_taken_o (taken)
   );

   assign ex_idx       = ex_pc_i[BHT_IDX_W+1:2];
   assign if_idx       = if_pc_i[BHT_IDX_W+1:2];
   assign unused_if_pc = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0]};

   always_comb begin
      is_cond = is_cond_br(br_cond_i);
      is_cf   = is_cond || (opcode_i == JUMP) || (opcode_i == JUMP_R);
      if (!is_cond && opcode_i == JUMP_R) target = (rs1_i + ex_imm_i) & ~32'h1;
      else                                target = ex_pc_i + ex_imm_i;
      next_pc    = taken ? target : ex_pc_i + 32'd4;
      // Only IDLE resolves: while a redirect is pending the EX slot is stale.
      mispredict = ex_valid_i && is_cf && (state_q == IDLE) &&
                   ((taken != pred_taken_i) || (taken && (target != pred_target_i)));
      bht_upd    = ex_valid_i && is_cond && (state_q == IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (mispredict)    state_d = REDIRECT;
         REDIRECT: if (redir_ready_i) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_comb begin
      flush_o       = mispredict;
      stall_o       = (state_q == REDIRECT);
      redir_valid_o = (state_q == REDIRECT);
      dbg_state_o   = state_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         redir_pc_q    <= 32'h0;
         mispred_cnt_q <= 32'h0;
      end else if (mispredict) begin
         redir_pc_q    <= next_pc;
         mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_N; i++) bht_q[i] <= CNT_INIT;
      end else if (bht_upd) begin
         bht_q[ex_idx] <= bht_cnt_next(bht_q[ex_idx], taken);
      end
   end

   // Lookup reads the pre-update counter; no same-cycle bypass.
   assign bht_pred_o    = bht_q[if_idx][BHT_CNT_W-1];
   assign redir_pc_o    = redir_pc_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: redirect scoreboard plus BHT and counter checks.
module tb_branch_resolve_ctrl;
   import core_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ex_valid_i;
   logic [31:0]   ex_pc_i, ex_imm_i, rs1_i, rs2_i, pred_target_i, if_pc_i;
   br_cond_e      br_cond_i;
   rv32_opcodes_e opcode_i;
   logic          pred_taken_i, redir_ready_i;
   logic          flush_o, stall_o, redir_valid_o, bht_pred_o, dbg_state_o;
   logic [31:0]   redir_pc_o, mispred_cnt_o;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   exp_cnt = 32'h0;

   logic [31:0]   r_pc, r_imm, r_tgt, r_ptgt;
   logic          r_pt, r_mis;

   always #5 clk_i = ~clk_i;

   branch_resolve_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ex_valid_i    (ex_valid_i),
      .ex_pc_i       (ex_pc_i),
      .ex_imm_i      (ex_imm_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .br_cond_i     (br_cond_i),
      .opcode_i      (opcode_i),
      .pred_taken_i  (pred_taken_i),
      .pred_target_i (pred_target_i),
      .flush_o       (flush_o),
      .stall_o       (stall_o),
      .redir_valid_o (redir_valid_o),
      .redir_pc_o    (redir_pc_o),
      .redir_ready_i (redir_ready_i),
      .if_pc_i       (if_pc_i),
      .bht_pred_o    (bht_pred_o),
      .mispred_cnt_o (mispred_cnt_o),
      .dbg_state_o   (dbg_state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive_ex(input br_cond_e c, input rv32_opcodes_e op, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                           input logic pt, input logic [31:0] ptgt);
      ex_valid_i    = 1'b1;
      br_cond_i     = c;
      opcode_i      = op;
      ex_pc_i       = pc;
      ex_imm_i      = imm;
      rs1_i         = a;
      rs2_i         = b;
      pred_taken_i  = pt;
      pred_target_i = ptgt;
   endtask

   // Called at posedge+1; presents one instruction for one cycle. exp_bp < 0 skips the lookup check.
   task automatic issue(input br_cond_e c, input rv32_opcodes_e op, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ptgt,
                        input logic exp_mis, input logic [31:0] exp_npc, input int exp_bp);
      drive_ex(c, op, pc, imm, a, b, pt, ptgt);
      #1;
      check("flush", 32'(flush_o), 32'(exp_mis));
      if (exp_bp >= 0) check("bht_same_cycle", 32'(bht_pred_o), 32'(exp_bp));
      if (exp_mis) begin
         exp_q.push_back(exp_npc);
         exp_cnt++;
      end
      @(posedge clk_i); #1;
      ex_valid_i = 1'b0;
      check("redir_valid_after_issue", 32'(redir_valid_o), 32'(exp_mis));
      check("mispred_cnt", mispred_cnt_o, exp_cnt);
   endtask

   task automatic peek(input logic [31:0] pc, input logic exp);
      if_pc_i = pc;
      #1;
      check("bht_pred", 32'(bht_pred_o), 32'(exp));
   endtask

   // Holds ready low for 'hold' cycles (optionally poking mispredicting EX pulses), then accepts.
   task automatic accept(input int hold, input logic poke);
      logic [31:0] exp_pc;
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() == 0) return;
      exp_pc = exp_q.pop_front();
      redir_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (poke) drive_ex(BEQ, BRANCH, 32'h804, 32'h40, 32'h7, 32'h7, 1'b0, 32'h0);
         #1;
         check("hold_flush", 32'(flush_o), 32'd0);
         check("hold_stall", 32'(stall_o), 32'd1);
         check("hold_pc", redir_pc_o, exp_pc);
         @(posedge clk_i); #1;
         ex_valid_i = 1'b0;
         check("hold_cnt", mispred_cnt_o, exp_cnt);
      end
      redir_ready_i = 1'b1;
      #1;
      check("accept_valid", 32'(redir_valid_o), 32'd1);
      check("accept_pc", redir_pc_o, exp_pc);
      @(posedge clk_i); #1;
      redir_ready_i = 1'b0;
      check("idle_valid", 32'(redir_valid_o), 32'd0);
      check("idle_stall", 32'(stall_o), 32'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      redir_ready_i = 1'b0;
      if_pc_i = 32'h0;
      drive_ex(BR_NONE, OP_REG, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      ex_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_valid", 32'(redir_valid_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_flush", 32'(flush_o), 32'd0);
      check("rst_pc", redir_pc_o, 32'd0);
      check("rst_cnt", mispred_cnt_o, 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'(IDLE));
      check("rst_bht", 32'(bht_pred_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Taken BEQ predicted not-taken; lookup at same index sees the old counter.
      if_pc_i = 32'h100;
      issue(BEQ, BRANCH, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 32'h120, 0);
      check("state_redirect", 32'(dbg_state_o), 32'(REDIRECT));
      peek(32'h100, 1'b1);
      accept(0, 1'b0);

      // Not-taken BNE then correctly predicted taken BEQ at idx 1: 01->00->01.
      issue(BNE, BRANCH, 32'h104, 32'h10, 32'd9, 32'd9, 1'b0, 32'h0, 1'b0, 32'h0, -1);
      peek(32'h104, 1'b0);
      issue(BEQ, BRANCH, 32'h104, 32'h10, 32'd9, 32'd9, 1'b1, 32'h114, 1'b0, 32'h0, -1);
      peek(32'h104, 1'b0);

      // JUMP_R target masking; jumps at idx 1 must leave the counter at 01.
      issue(BR_NONE, JUMP_R, 32'h104, 32'h4, 32'h203, 32'h0, 1'b1, 32'h206, 1'b0, 32'h0, -1);
      issue(BR_NONE, JUMP_R, 32'h104, 32'h4, 32'h203, 32'h0, 1'b1, 32'h200, 1'b1, 32'h206, -1);
      accept(0, 1'b0);
      issue(BR_NONE, JUMP, 32'h104, 32'h80, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h184, -1);
      accept(1, 1'b0);
      peek(32'h104, 1'b0);

      // Not-taken BLT predicted taken redirects to pc+4; non-cf never mispredicts.
      issue(BLT, BRANCH, 32'h60c, 32'h40, 32'd1, 32'hffffffff, 1'b1, 32'h700, 1'b1, 32'h610, -1);
      accept(0, 1'b0);
      issue(BR_NONE, OP_REG, 32'h700, 32'h0, 32'h0, 32'h0, 1'b1, 32'h900, 1'b0, 32'h0, -1);

      // Pending redirect held 3 cycles with ignored mispredicting EX pulses at idx 1.
      issue(BR_NONE, JUMP, 32'h400, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h440, -1);
      accept(3, 1'b1);
      peek(32'h804, 1'b0);

      // Saturation: three taken BLTs then two not-taken at idx 2.
      for (int i = 0; i < 3; i++) begin
         issue(BLT, BRANCH, 32'h508, 32'h10, 32'hffffffff, 32'd1, 1'b1, 32'h518, 1'b0, 32'h0, -1);
         peek(32'h508, 1'b1);
      end
      issue(BLT, BRANCH, 32'h508, 32'h10, 32'd1, 32'hffffffff, 1'b0, 32'h0, 1'b0, 32'h0, -1);
      peek(32'h508, 1'b1);
      issue(BLT, BRANCH, 32'h508, 32'h10, 32'd1, 32'hffffffff, 1'b0, 32'h0, 1'b0, 32'h0, -1);
      peek(32'h508, 1'b0);

      // Random JUMPs against a small target model.
      for (int i = 0; i < 16; i++) begin
         r_pc   = $urandom() & 32'hfffffffc;
         r_imm  = $urandom();
         r_tgt  = r_pc + r_imm;
         r_pt   = 1'($urandom_range(0, 1));
         r_ptgt = ($urandom_range(0, 1) == 1) ? r_tgt : $urandom();
         r_mis  = !r_pt || (r_ptgt != r_tgt);
         issue(BR_NONE, JUMP, r_pc, r_imm, 32'h0, 32'h0, r_pt, r_ptgt, r_mis, r_tgt, -1);
         if (r_mis) accept($urandom_range(0, 2), 1'b0);
      end

      // Reset mid-REDIRECT with ready high: pending redirect dropped, BHT reinitialised.
      peek(32'h100, 1'b1);
      issue(BR_NONE, JUMP, 32'h40, 32'h8, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h48, -1);
      redir_ready_i = 1'b1;
      rst_i = 1'b1;
      #1;
      exp_q.delete();
      exp_cnt = 32'h0;
      check("rst_mid_valid", 32'(redir_valid_o), 32'd0);
      check("rst_mid_stall", 32'(stall_o), 32'd0);
      check("rst_mid_cnt", mispred_cnt_o, 32'd0);
      check("rst_mid_pc", redir_pc_o, 32'd0);
      peek(32'h100, 1'b0);
      peek(32'h508, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      redir_ready_i = 1'b0;
      check("post_rst_state", 32'(dbg_state_o), 32'(IDLE));
      issue(BGEU, BRANCH, 32'h20, 32'h100, 32'h5, 32'h5, 1'b0, 32'h0, 1'b1, 32'h120, -1);
      accept(0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
